// File: rtl/comparator_seq.sv
// Chunk-serial N-bit comparator: scans W bits per cycle from the MSB and stops at the first
// differing chunk. Operands come in and the result goes out on valid/ready handshakes.
module comparator_seq #(
    parameter int N      = 32,
    parameter int W      = 4,
    parameter int SIGNED = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         eq,
    output logic         lt,
    output logic         gt
);
    localparam int C  = N / W;
    localparam int CW = (C > 1) ? $clog2(C) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_r, state_s;
    logic [N-1:0]  a_r, a_s, b_r, b_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic          out_valid_r, out_valid_s;
    logic          eq_r, eq_s, lt_r, lt_s, gt_r, gt_s;
    logic [W-1:0]  chunk_a_s, chunk_b_s;
    logic          first_s;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    function automatic logic [W-1:0] bias_sign(input logic [W-1:0] c, input logic en);
        logic [W-1:0] m;
        m        = '0;
        m[W-1]   = en;
        return c ^ m;
    endfunction

    // Top chunk of each operand, sign-biased on the MSB chunk of a signed compare.
    always_comb begin
        first_s   = (cnt_r == CW'(C - 1)) && (SIGNED != 0);
        chunk_a_s = bias_sign(a_r[N-1 -: W], first_s);
        chunk_b_s = bias_sign(b_r[N-1 -: W], first_s);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_s     = state_r;
        a_s         = a_r;
        b_s         = b_r;
        cnt_s       = cnt_r;
        out_valid_s = out_valid_r;
        eq_s        = eq_r;
        lt_s        = lt_r;
        gt_s        = gt_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    a_s     = a;
                    b_s     = b;
                    cnt_s   = CW'(C - 1);
                    state_s = SCAN;
                end else begin
                    state_s = IDLE;
                end
            end
            SCAN: begin
                if (chunk_a_s != chunk_b_s) begin
                    lt_s        = (chunk_a_s < chunk_b_s);
                    gt_s        = (chunk_a_s > chunk_b_s);
                    eq_s        = 1'b0;
                    out_valid_s = 1'b1;
                    state_s     = DONE;
                end else if (cnt_r == '0) begin
                    eq_s        = 1'b1;
                    lt_s        = 1'b0;
                    gt_s        = 1'b0;
                    out_valid_s = 1'b1;
                    state_s     = DONE;
                end else begin
                    a_s   = a_r << W;
                    b_s   = b_r << W;
                    cnt_s = cnt_r - CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_s = 1'b0;
                    eq_s        = 1'b0;
                    lt_s        = 1'b0;
                    gt_s        = 1'b0;
                    state_s     = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                out_valid_s = 1'b0;
                eq_s        = 1'b0;
                lt_s        = 1'b0;
                gt_s        = 1'b0;
                state_s     = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            a_r         <= '0;
            b_r         <= '0;
            cnt_r       <= '0;
            out_valid_r <= 1'b0;
            eq_r        <= 1'b0;
            lt_r        <= 1'b0;
            gt_r        <= 1'b0;
        end else begin
            state_r     <= state_s;
            a_r         <= a_s;
            b_r         <= b_s;
            cnt_r       <= cnt_s;
            out_valid_r <= out_valid_s;
            eq_r        <= eq_s;
            lt_r        <= lt_s;
            gt_r        <= gt_s;
        end
    end

    // Ready drops as soon as reset is asserted, without waiting for an edge.
    assign in_ready  = (state_r == IDLE) && rst_n;
    assign out_valid = out_valid_r;
    assign eq        = eq_r;
    assign lt        = lt_r;
    assign gt        = gt_r;
endmodule

// File: tb/tb_comparator_seq.sv
// Randomized bench for comparator_seq: a signed and an unsigned instance share stimulus and are
// checked against full-width arithmetic compares and a first-differing-chunk latency model.
module tb_comparator_seq;
    localparam int N = 32;
    localparam int W = 4;
    localparam int C = N / W;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         out_ready;
    logic [N-1:0] a, b;
    logic         ir_s1, ov_s1, eq_s1, lt_s1, gt_s1;
    logic         ir_u0, ov_u0, eq_u0, lt_u0, gt_u0;

    int n_checks = 0;
    int n_errors = 0;

    comparator_seq #(.N(N), .W(W), .SIGNED(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_s1),
        .a(a), .b(b), .out_valid(ov_s1), .out_ready(out_ready),
        .eq(eq_s1), .lt(lt_s1), .gt(gt_s1)
    );

    comparator_seq #(.N(N), .W(W), .SIGNED(0)) dut_u (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_u0),
        .a(a), .b(b), .out_valid(ov_u0), .out_ready(out_ready),
        .eq(eq_u0), .lt(lt_u0), .gt(gt_u0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int model_latency(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [N-1:0] d;
        d = x ^ y;
        for (int i = 0; i < C; i++) begin
            if (d[N-1-i*W -: W] != '0) return i + 1;
        end
        return C;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_results(input string tag, input logic [N-1:0] x, input logic [N-1:0] y);
        logic [2:0] exp_s, exp_u;
        exp_s = {($signed(x) == $signed(y)), ($signed(x) < $signed(y)), ($signed(x) > $signed(y))};
        exp_u = {(x == y), (x < y), (x > y)};
        check({tag, "_res_s"}, {29'd0, eq_s1, lt_s1, gt_s1}, {29'd0, exp_s});
        check({tag, "_res_u"}, {29'd0, eq_u0, lt_u0, gt_u0}, {29'd0, exp_u});
        check({tag, "_ov"}, {30'd0, ov_s1, ov_u0}, 32'd3);
        check({tag, "_irdy"}, {30'd0, ir_s1, ir_u0}, 32'd0);
    endtask

    // One full transaction: accept, measure latency, hold in DONE for `hold` cycles, release.
    task automatic run_op(input string tag, input logic [N-1:0] x, input logic [N-1:0] y,
                          input int hold);
        int cyc;
        int lim;
        lim = 0;
        while (!(ir_s1 && ir_u0) && lim < 30) begin
            tick();
            lim++;
        end
        check({tag, "_idle"}, {30'd0, ir_s1, ir_u0}, 32'd3);
        a        = x;
        b        = y;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cyc      = 0;
        while (!ov_u0 && cyc < 20) begin
            out_ready = 1'($urandom_range(0, 1));
            a         = $urandom;
            b         = $urandom;
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        check({tag, "_lat"}, 32'(cyc), 32'(model_latency(x, y)));
        check_results(tag, x, y);
        for (int h = 0; h < hold; h++) begin
            in_valid = ~in_valid;
            a        = $urandom;
            b        = $urandom;
            tick();
            check_results({tag, "_hold"}, x, y);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_rel"}, {28'd0, ov_s1, ov_u0, ir_s1, ir_u0}, 32'h3);
        check({tag, "_clr"}, {26'd0, eq_s1, lt_s1, gt_s1, eq_u0, lt_u0, gt_u0}, 32'd0);
    endtask

    initial begin
        int seen;
        logic [N-1:0] rx, ry;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        tick();
        tick();
        check("rst_irdy", {30'd0, ir_s1, ir_u0}, 32'd0);
        check("rst_out", {24'd0, ov_s1, eq_s1, lt_s1, gt_s1, ov_u0, eq_u0, lt_u0, gt_u0}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_rel_irdy", {30'd0, ir_s1, ir_u0}, 32'd3);

        run_op("eq_1234", 32'h1234_5678, 32'h1234_5678, 0);
        run_op("sign_msb", 32'h8000_0000, 32'h0000_0001, 0);
        run_op("last_chunk", 32'd5, 32'd3, 0);
        run_op("all_ones", 32'hFFFF_FFFF, 32'h0000_0000, 0);
        run_op("hold5", 32'h7000_0000, 32'h9000_0000, 5);
        run_op("eq_zero", 32'h0000_0000, 32'h0000_0000, 1);

        // Abort mid-scan with reset: no result may ever appear for this operation.
        a        = 32'hA5A5_A5A5;
        b        = 32'hA5A5_A5A5;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("abort_irdy_low", {30'd0, ir_s1, ir_u0}, 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("abort_irdy_high", {30'd0, ir_s1, ir_u0}, 32'd3);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ov_s1 || ov_u0) seen++;
        end
        check("abort_no_result", 32'(seen), 32'd0);
        run_op("after_abort", 32'd1, 32'd2, 0);

        for (int t = 0; t < 60; t++) begin
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(0, 3))
                0: ry = rx;
                1: ry = rx ^ (32'h1 << $urandom_range(0, 31));
                2: ry = {rx[31:16], ry[15:0]};
                default: ry = ry;
            endcase
            run_op("rand", rx, ry, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
